// File: rtl/mem_stage_if.sv
// Bundle of the execute-side handshake, data-memory port and writeback
// signals of the memory stage. The master side is the memory stage itself;
// the slave side is its environment (execute stage, data memory, writeback).
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_alu_out;
  logic [XLEN-1:0] ex_rs2;
  logic [2:0]      ex_funct3;
  logic            ex_load;
  logic            ex_store;
  logic [4:0]      ex_rd;

  logic            dmem_en;
  logic [3:0]      dmem_we;
  logic [XLEN-3:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            misalign;

  modport master (
    input  ex_valid, ex_alu_out, ex_rs2, ex_funct3, ex_load, ex_store, ex_rd,
    input  dmem_rdata,
    output ex_ready, dmem_en, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_rd, wb_data, misalign
  );

  modport slave (
    output ex_valid, ex_alu_out, ex_rs2, ex_funct3, ex_load, ex_store, ex_rd,
    output dmem_rdata,
    input  ex_ready, dmem_en, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_rd, wb_data, misalign
  );
endinterface

// File: rtl/mem_stage.sv
// RISC-V style memory stage. ALU results pass straight to writeback one
// cycle after accept; stores spend one cycle driving the data-memory port;
// loads drive a read strobe, wait one cycle for the returned word, then
// extract and extend the addressed byte/half/word. Misaligned accesses are
// dropped and flagged with a one-cycle misalign pulse.
module mem_stage #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            accept;
  logic            is_load;
  logic            is_store;
  logic            is_mem;
  logic            misaligned;
  logic [1:0]      a_lo;
  logic [3:0]      st_we;
  logic [XLEN-1:0] st_wdata;

  logic            pend_load;
  logic [2:0]      pend_funct3;
  logic [1:0]      pend_off;
  logic [4:0]      pend_rd;

  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_data;

  // Decode the presented operation: kind, alignment and store lane layout.
  always_comb begin
    a_lo       = bus.ex_alu_out[1:0];
    is_load    = bus.ex_load;
    is_store   = bus.ex_store & ~bus.ex_load;
    is_mem     = is_load | is_store;
    accept     = bus.ex_valid & (state == IDLE);
    misaligned = 1'b0;
    if (is_mem) begin
      if (bus.ex_funct3[1]) begin
        misaligned = (a_lo != 2'b00);
      end else if (bus.ex_funct3[0]) begin
        misaligned = a_lo[0];
      end
    end
    st_we    = 4'b1111;
    st_wdata = bus.ex_rs2;
    case (bus.ex_funct3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << a_lo;
        st_wdata = {4{bus.ex_rs2[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << {a_lo[1], 1'b0};
        st_wdata = {2{bus.ex_rs2[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = bus.ex_rs2;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and ready; only aligned memory ops leave IDLE.
  always_comb begin
    state_nxt    = state;
    bus.ex_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.ex_ready = 1'b1;
        if (accept && is_mem && !misaligned) begin
          state_nxt = REQ;
        end
      end
      REQ:     state_nxt = pend_load ? RESP : IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    ld_shift = bus.dmem_rdata >> {pend_off, 3'b000};
    case (pend_funct3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'h000000, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'h0000, ld_shift[15:0]};
      default: ld_data = bus.dmem_rdata;
    endcase
  end

  // Registered memory port, writeback and misalign pulses, pending-load info.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dmem_en    <= 1'b0;
      bus.dmem_we    <= 4'b0000;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.wb_valid   <= 1'b0;
      bus.wb_rd      <= 5'd0;
      bus.wb_data    <= '0;
      bus.misalign   <= 1'b0;
      pend_load      <= 1'b0;
      pend_funct3    <= 3'b000;
      pend_off       <= 2'b00;
      pend_rd        <= 5'd0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.misalign <= 1'b0;
      bus.dmem_en  <= 1'b0;
      bus.dmem_we  <= 4'b0000;
      if (accept) begin
        if (misaligned) begin
          bus.misalign <= 1'b1;
        end else if (is_mem) begin
          bus.dmem_en    <= 1'b1;
          bus.dmem_we    <= is_load ? 4'b0000 : st_we;
          bus.dmem_addr  <= bus.ex_alu_out[XLEN-1:2];
          bus.dmem_wdata <= is_load ? '0 : st_wdata;
          pend_load      <= is_load;
          pend_funct3    <= bus.ex_funct3;
          pend_off       <= a_lo;
          pend_rd        <= bus.ex_rd;
        end else begin
          bus.wb_valid <= 1'b1;
          bus.wb_rd    <= bus.ex_rd;
          bus.wb_data  <= bus.ex_alu_out;
        end
      end
      if (state == RESP) begin
        bus.wb_valid <= 1'b1;
        bus.wb_rd    <= pend_rd;
        bus.wb_data  <= ld_data;
      end
    end
  end

endmodule
